// File: rtl/servo_move_sequencer_if.sv
// rtl/servo_move_sequencer_if.sv - move command handshake bundle for servo_move_sequencer
interface servo_move_sequencer_if #(
  parameter int DUR_W = 12
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_dir;
  logic [DUR_W-1:0] cmd_ms;

  modport master (output cmd_valid, output cmd_dir, output cmd_ms, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_dir, input cmd_ms, output cmd_ready);
endinterface

// File: rtl/servo_move_sequencer.sv
// rtl/servo_move_sequencer.sv - queued timed-motion sequencer driving the servo controller
module servo_move_sequencer #(
  parameter int TICK_CYCLES = 50000,
  parameter int SETTLE_MS   = 20,
  parameter int DEPTH       = 4,
  parameter int DUR_W       = 12
) (
  input  logic                   clk,
  input  logic                   resetn,
  servo_move_sequencer_if.slave  cmd,
  input  logic                   abort,
  output logic [2:0]             direction,
  output logic                   useServo,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] queue_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SETTLE} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [DUR_W-1:0] ms_q, ms_d;
  logic             init_q;
  logic             servo_d, done_d;
  logic [2:0]       dir_d;

  logic [2:0]       fifo_dir [DEPTH];
  logic [DUR_W-1:0] fifo_ms  [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count_q;
  logic             push, pop;
  logic [2:0]       head_dir, exec_dir;
  logic [DUR_W-1:0] head_ms;
  logic             tick, last_ms;

  assign cmd.cmd_ready = !abort && (count_q < (AW+1)'(DEPTH));
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign head_dir      = fifo_dir[rd_ptr];
  assign head_ms       = fifo_ms[rd_ptr];
  // Reserved codes are kept in the queue but drive the wheels as stop.
  assign exec_dir      = (head_dir > 3'd4) ? 3'd0 : head_dir;
  assign tick          = (presc_q == PW'(TICK_CYCLES - 1));
  assign last_ms       = (ms_q == DUR_W'(1));
  assign busy          = (state_q != S_IDLE) || (count_q != '0);
  assign queue_count   = count_q;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dir[wr_ptr] <= cmd.cmd_dir;
      fifo_ms[wr_ptr]  <= cmd.cmd_ms;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (abort) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (count_q != '0 && head_ms != '0) state_d = S_RUN;
        S_RUN:    if (tick && last_ms) state_d = (SETTLE_MS == 0) ? S_IDLE : S_SETTLE;
        S_SETTLE: if (tick && last_ms) state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // The settle interval reuses ms_left, reloaded with SETTLE_MS at the stop edge.
  always_comb begin
    pop     = 1'b0;
    servo_d = 1'b0;
    done_d  = 1'b0;
    dir_d   = direction;
    presc_d = presc_q;
    ms_d    = ms_q;
    if (abort) begin
      servo_d = 1'b1;
      dir_d   = 3'd0;
      presc_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          presc_d = '0;
          if (count_q != '0) begin
            pop = 1'b1;
            if (head_ms != '0) begin
              dir_d   = exec_dir;
              servo_d = 1'b1;
              ms_d    = head_ms;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        S_RUN, S_SETTLE: begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            ms_d = ms_q - DUR_W'(1);
            if (last_ms && state_q == S_RUN) begin
              dir_d   = 3'd0;
              servo_d = 1'b1;
              done_d  = 1'b1;
              ms_d    = DUR_W'(SETTLE_MS);
            end
          end
        end
        default: presc_d = '0;
      endcase
    end
    // First edge out of reset latches stop downstream; the queue is empty then.
    if (init_q) begin
      servo_d = 1'b1;
      dir_d   = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_q   <= '0;
      ms_q      <= '0;
      init_q    <= 1'b1;
      direction <= 3'd0;
      useServo  <= 1'b0;
      done      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      ms_q      <= ms_d;
      init_q    <= 1'b0;
      direction <= dir_d;
      useServo  <= servo_d;
      done      <= done_d;
    end
  end
endmodule

// File: tb/tb_servo_move_sequencer.sv
// tb/tb_servo_move_sequencer.sv - directed self-checking bench for servo_move_sequencer
module tb_servo_move_sequencer;
  logic       clk = 1'b0;
  logic       resetn;
  logic       abort;
  logic [2:0] direction;
  logic       useServo, busy, done;
  logic [2:0] queue_count;

  servo_move_sequencer_if #(.DUR_W(12)) cmd_if();

  servo_move_sequencer #(
    .TICK_CYCLES(10), .SETTLE_MS(2), .DEPTH(4), .DUR_W(12)
  ) dut (
    .clk(clk), .resetn(resetn), .cmd(cmd_if), .abort(abort),
    .direction(direction), .useServo(useServo), .busy(busy),
    .done(done), .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  dir;
    logic [11:0] ms;
    logic        servo;
    logic [2:0]  exp_dir;
    int          exp_cyc;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [2:0] dir;
    logic       servo;
    logic       done;
  } ev_t;

  int   tests = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_fall = 0;
  logic busy_prev = 1'b0;
  ev_t  ev[$];
  vec_t vt[9];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (useServo || done) ev.push_back('{cyc, direction, useServo, done});
    if (busy_prev && !busy) busy_fall = cyc;
    busy_prev = busy;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] d, input logic [11:0] m);
    int n = 0;
    cmd_if.cmd_dir   = d;
    cmd_if.cmd_ms    = m;
    cmd_if.cmd_valid = 1'b1;
    while (!cmd_if.cmd_ready && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) chk("push_timeout", n, 0);
    step();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) chk(name, n, 0);
    step();
    step();
  endtask

  initial begin
    int   n;
    ev_t  s, p;
    logic [2:0]  fdir [5];
    logic [11:0] fms  [5];

    vt[0] = '{3'b001, 12'd3, 1'b1, 3'b001, 30};
    vt[1] = '{3'b010, 12'd1, 1'b1, 3'b010, 10};
    vt[2] = '{3'b011, 12'd2, 1'b1, 3'b011, 20};
    vt[3] = '{3'b100, 12'd4, 1'b1, 3'b100, 40};
    vt[4] = '{3'b110, 12'd2, 1'b1, 3'b000, 20};
    vt[5] = '{3'b111, 12'd1, 1'b1, 3'b000, 10};
    vt[6] = '{3'b101, 12'd3, 1'b1, 3'b000, 30};
    vt[7] = '{3'b010, 12'd0, 1'b0, 3'b000, 0};
    vt[8] = '{3'b000, 12'd1, 1'b1, 3'b000, 10};
    fdir[0] = 3'b001; fms[0] = 12'd1;
    fdir[1] = 3'b010; fms[1] = 12'd2;
    fdir[2] = 3'b011; fms[2] = 12'd1;
    fdir[3] = 3'b100; fms[3] = 12'd3;
    fdir[4] = 3'b001; fms[4] = 12'd1;

    resetn = 1'b1;
    abort = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_dir = 3'd0;
    cmd_if.cmd_ms = 12'd0;
    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_direction", int'(direction), 0);
    chk("rst_useServo", int'(useServo), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_queue_count", int'(queue_count), 0);
    chk("rst_cmd_ready", int'(cmd_if.cmd_ready), 1);

    resetn = 1'b1;
    step();
    chk("post_rst_useServo", int'(useServo), 1);
    chk("post_rst_direction", int'(direction), 0);
    n = 0;
    repeat (8) begin
      step();
      if (useServo) n++;
    end
    chk("post_rst_quiet", n, 0);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_cmd_ready", int'(cmd_if.cmd_ready), 1);

    for (int i = 0; i < 9; i++) begin
      ev.delete();
      push(vt[i].dir, vt[i].ms);
      wait_idle($sformatf("vec%0d_idle_timeout", i));
      if (vt[i].servo) begin
        chk($sformatf("vec%0d_events", i), ev.size(), 2);
        if (ev.size() == 2) begin
          chk($sformatf("vec%0d_start_dir", i), int'(ev[0].dir), int'(vt[i].exp_dir));
          chk($sformatf("vec%0d_start_done", i), int'(ev[0].done), 0);
          chk($sformatf("vec%0d_stop_dir", i), int'(ev[1].dir), 0);
          chk($sformatf("vec%0d_stop_done", i), int'(ev[1].done), 1);
          chk($sformatf("vec%0d_move_cycles", i), ev[1].cyc - ev[0].cyc, vt[i].exp_cyc);
          chk($sformatf("vec%0d_settle_cycles", i), busy_fall - ev[1].cyc, 20);
        end
      end else begin
        chk($sformatf("vec%0d_events", i), ev.size(), 1);
        if (ev.size() == 1) begin
          chk($sformatf("vec%0d_zero_servo", i), int'(ev[0].servo), 0);
          chk($sformatf("vec%0d_zero_done", i), int'(ev[0].done), 1);
        end
      end
    end

    ev.delete();
    for (int i = 0; i < 5; i++) push(fdir[i], fms[i]);
    chk("fill_queue_count", int'(queue_count), 4);
    chk("fill_cmd_ready", int'(cmd_if.cmd_ready), 0);
    wait_idle("fill_idle_timeout");
    chk("fill_events", ev.size(), 10);
    if (ev.size() == 10) begin
      for (int i = 0; i < 5; i++) begin
        s = ev[2*i];
        p = ev[2*i+1];
        chk($sformatf("fill%0d_dir", i), int'(s.dir), int'(fdir[i]));
        chk($sformatf("fill%0d_stop_done", i), int'(p.done), 1);
        chk($sformatf("fill%0d_stop_dir", i), int'(p.dir), 0);
        chk($sformatf("fill%0d_cycles", i), p.cyc - s.cyc, int'(fms[i]) * 10);
        if (i > 0) chk($sformatf("fill%0d_gap", i), s.cyc - ev[2*i-1].cyc, 21);
      end
    end

    ev.delete();
    push(3'b001, 12'd5);
    push(3'b010, 12'd1);
    push(3'b011, 12'd1);
    chk("abort_pre_count", int'(queue_count), 2);
    repeat (3) step();
    chk("abort_pre_dir", int'(direction), 1);
    abort = 1'b1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_dir = 3'b100;
    cmd_if.cmd_ms = 12'd1;
    #1;
    chk("abort_cmd_ready", int'(cmd_if.cmd_ready), 0);
    step();
    chk("abort_direction", int'(direction), 0);
    chk("abort_useServo", int'(useServo), 1);
    chk("abort_queue_count", int'(queue_count), 0);
    chk("abort_done", int'(done), 0);
    step();
    chk("abort_repeat_useServo", int'(useServo), 1);
    abort = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    step();
    chk("abort_release_useServo", int'(useServo), 0);
    chk("abort_release_count", int'(queue_count), 0);
    chk("abort_release_busy", int'(busy), 0);
    repeat (5) step();
    n = 0;
    foreach (ev[k]) if (ev[k].done) n++;
    chk("abort_no_done", n, 0);

    push(3'b001, 12'd1);
    n = 0;
    while (!done && n < 500) begin
      step();
      n++;
    end
    chk("settle_reach_done", int'(done), 1);
    repeat (5) step();
    push(3'b010, 12'd1);
    chk("settle_busy", int'(busy), 1);
    chk("settle_count", int'(queue_count), 1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_count", int'(queue_count), 0);
    chk("async_rst_useServo", int'(useServo), 0);
    chk("async_rst_direction", int'(direction), 0);
    chk("async_rst_done", int'(done), 0);
    step();
    resetn = 1'b1;
    step();
    chk("rerst_useServo", int'(useServo), 1);
    chk("rerst_direction", int'(direction), 0);
    step();
    chk("rerst_quiet", int'(useServo), 0);
    chk("rerst_busy", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
